// File: rtl/snd_pkg.sv
// Shared constants and state encoding for the sound player and sound LUT.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package snd_pkg;

    localparam int SND_ADDR_W   = 5;
    localparam int SND_PERIOD_W = 18;
    localparam int SND_DUR_W    = 8;
    localparam int SND_TICK_DIV = 500000;   // 10 ms per duration tick at 50 MHz

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_PLAY  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

endpackage

// File: rtl/snd_player_if.sv
// Request/response link between the sound player (master) and the sound LUT (slave).
// Latency: set by the LUT; the player holds the request until lut_valid.
// Backpressure: lut_req/lut_addr stay stable until the LUT answers with lut_valid.
//   lut_req         master -> slave   fetch request
//   lut_addr        master -> slave   entry address
//   lut_valid       slave  -> master  response strobe
//   lut_half_period slave  -> master  tone half-period in clk cycles, 0 = rest
//   lut_dur         slave  -> master  duration in ticks, 0 = skip entry
//   lut_last        slave  -> master  entry is last in sequence
interface snd_player_if
    import snd_pkg::*;
#(
    parameter int ADDR_W   = SND_ADDR_W,
    parameter int PERIOD_W = SND_PERIOD_W,
    parameter int DUR_W    = SND_DUR_W
);
    logic                lut_req;
    logic [ADDR_W-1:0]   lut_addr;
    logic                lut_valid;
    logic [PERIOD_W-1:0] lut_half_period;
    logic [DUR_W-1:0]    lut_dur;
    logic                lut_last;

    modport master (
        output lut_req, lut_addr,
        input  lut_valid, lut_half_period, lut_dur, lut_last
    );

    modport slave (
        input  lut_req, lut_addr,
        output lut_valid, lut_half_period, lut_dur, lut_last
    );
endinterface

// File: rtl/snd_tone_gen.sv
// Square-wave generator: toggles spk every half_period cycles while enabled.
// Latency: first toggle half_period cycles after enable rises.
// Backpressure: none; clears counter and output whenever enable=0.
//   clk, rst     clock, async active-high reset
//   enable       run the tone; 0 clears counter and forces spk=0
//   half_period  cycles between toggles; 0 = rest (spk held 0)
//   spk          registered square-wave output
module snd_tone_gen #(
    parameter int PERIOD_W = 18
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] half_period,
    output logic                spk
);
    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] cnt_last;

    assign cnt_last = half_period - 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            spk <= 1'b0;
        end else if (!enable || half_period == '0) begin
            cnt <= '0;
            spk <= 1'b0;
        end else if (cnt == cnt_last) begin
            cnt <= '0;
            spk <= ~spk;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/snd_player.sv
// Sound player: walks the note table over the LUT link and plays each entry on spk.
// Latency: PLAY starts the cycle after the LUT response; note = dur*TICK_DIV + TICK_DIV gap.
// Backpressure: waits indefinitely in FETCH with request held until lut_valid.
//   clk, rst       clock, async active-high reset
//   start / stop   single-cycle control pulses (stop wins)
//   loop           restart at address 0 when the sequence ends
//   lut            master side of the LUT fetch link
//   spk            square-wave speaker output
//   busy / done    not-idle level / one-cycle normal-end pulse
//   note_idx       address of the entry currently playing
module snd_player
    import snd_pkg::*;
#(
    parameter int ADDR_W   = SND_ADDR_W,
    parameter int PERIOD_W = SND_PERIOD_W,
    parameter int DUR_W    = SND_DUR_W,
    parameter int TICK_DIV = SND_TICK_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    snd_player_if.master      lut,
    output logic              spk,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] note_idx
);
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    state_t              state, state_n;
    logic [TICK_W-1:0]   tick_cnt, tick_n;
    logic [DUR_W-1:0]    dur_cnt, dur_cnt_n, dur_inc;
    logic [DUR_W-1:0]    dur_r, dur_n;
    logic [PERIOD_W-1:0] hp_r, hp_n;
    logic                last_r, last_n;
    logic                req_n;
    logic [ADDR_W-1:0]   addr_n, note_n, addr_after;
    logic                done_n;
    logic                entry_last, seq_end, tick_wrap, tone_en;

    assign tick_wrap  = (tick_cnt == TICK_LAST);
    assign dur_inc    = dur_cnt + 1'b1;
    // A skipped entry ends in its own capture cycle, so its last flag comes
    // straight from the response rather than from the capture register.
    assign entry_last = (state == S_FETCH) ? lut.lut_last : last_r;
    assign seq_end    = entry_last || (&lut.lut_addr);
    assign addr_after = seq_end ? '0 : lut.lut_addr + 1'b1;

    always_comb begin
        state_n   = state;
        req_n     = lut.lut_req;
        addr_n    = lut.lut_addr;
        tick_n    = tick_cnt;
        dur_cnt_n = dur_cnt;
        dur_n     = dur_r;
        hp_n      = hp_r;
        last_n    = last_r;
        note_n    = note_idx;
        done_n    = 1'b0;

        if (stop) begin
            state_n = S_IDLE;
            req_n   = 1'b0;
            addr_n  = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_n = S_FETCH;
                        req_n   = 1'b1;
                        addr_n  = '0;
                    end
                end
                S_FETCH: begin
                    if (!lut.lut_req) begin
                        // Re-issue after a skipped entry: request drops for one cycle first.
                        req_n = 1'b1;
                    end else if (lut.lut_valid) begin
                        hp_n   = lut.lut_half_period;
                        dur_n  = lut.lut_dur;
                        last_n = lut.lut_last;
                        req_n  = 1'b0;
                        if (lut.lut_dur == '0) begin
                            if (seq_end && !loop) begin
                                state_n = S_IDLE;
                                done_n  = 1'b1;
                                addr_n  = '0;
                            end else begin
                                addr_n = addr_after;
                            end
                        end else begin
                            state_n   = S_PLAY;
                            note_n    = lut.lut_addr;
                            tick_n    = '0;
                            dur_cnt_n = '0;
                        end
                    end
                end
                S_PLAY: begin
                    if (tick_wrap) begin
                        tick_n    = '0;
                        dur_cnt_n = dur_inc;
                        if (dur_inc == dur_r) begin
                            state_n = S_GAP;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (tick_wrap) begin
                        tick_n = '0;
                        if (seq_end && !loop) begin
                            state_n = S_IDLE;
                            done_n  = 1'b1;
                            addr_n  = '0;
                        end else begin
                            state_n = S_FETCH;
                            req_n   = 1'b1;
                            addr_n  = addr_after;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Tone runs only while PLAY continues, so the cycle leaving PLAY already
    // clears spk and GAP starts silent.
    assign tone_en = (state == S_PLAY) && (state_n == S_PLAY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            lut.lut_req  <= 1'b0;
            lut.lut_addr <= '0;
            tick_cnt     <= '0;
            dur_cnt      <= '0;
            dur_r        <= '0;
            hp_r         <= '0;
            last_r       <= 1'b0;
            note_idx     <= '0;
            done         <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            lut.lut_req  <= req_n;
            lut.lut_addr <= addr_n;
            tick_cnt     <= tick_n;
            dur_cnt      <= dur_cnt_n;
            dur_r        <= dur_n;
            hp_r         <= hp_n;
            last_r       <= last_n;
            note_idx     <= note_n;
            done         <= done_n;
            busy         <= (state_n != S_IDLE);
        end
    end

    snd_tone_gen #(
        .PERIOD_W (PERIOD_W)
    ) u_tone (
        .clk         (clk),
        .rst         (rst),
        .enable      (tone_en),
        .half_period (hp_r),
        .spk         (spk)
    );
endmodule

// File: tb/tb_snd_player.sv
module tb_snd_player;
    localparam int AW   = 5;
    localparam int PW   = 18;
    localparam int DW   = 8;
    localparam int TD   = 10;
    localparam int MAXC = 400;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic loop = 1'b0;
    logic spk, busy, done;
    logic [AW-1:0] note_idx;

    snd_player_if #(.ADDR_W(AW), .PERIOD_W(PW), .DUR_W(DW)) lif ();

    snd_player #(.ADDR_W(AW), .PERIOD_W(PW), .DUR_W(DW), .TICK_DIV(TD)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .loop     (loop),
        .lut      (lif),
        .spk      (spk),
        .busy     (busy),
        .done     (done),
        .note_idx (note_idx)
    );

    always #5 clk = ~clk;

    // Note table seen by the LUT model; stall = cycles request is held before valid.
    int tab_hp [32];
    int tab_dur[32];
    int tab_last[32];
    int tab_stall[32];

    // Expected per-cycle outputs, cycle 0 = first cycle after start is sampled.
    bit e_spk[MAXC], e_busy[MAXC], e_done[MAXC], e_req[MAXC];
    int e_addr[MAXC], e_play[MAXC], e_note[MAXC];
    logic [13:0] raw_v[MAXC];
    int model_end;

    int n_vec = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int cyc, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    task automatic clear_tab();
        for (int i = 0; i < 32; i++) begin
            tab_hp[i] = 1; tab_dur[i] = 1; tab_last[i] = 0; tab_stall[i] = 1;
        end
    endtask

    task automatic set_entry(input int a, input int hp, input int dur, input int last, input int stall);
        tab_hp[a] = hp; tab_dur[a] = dur; tab_last[a] = last; tab_stall[a] = stall;
    endtask

    // Schedule of the whole sequence from the table: each entry is a fetch of
    // stall+1 request cycles, then dur*TD play cycles and TD gap cycles
    // (or nothing for a skipped entry), then the next fetch or done.
    task automatic build_model(input bit lp);
        int t, a, v, pe, ec, cur;
        bit se, skip;
        for (int c = 0; c < MAXC; c++) begin
            e_spk[c] = 0; e_busy[c] = 0; e_done[c] = 0; e_req[c] = 0;
            e_addr[c] = 0; e_play[c] = -1; e_note[c] = -1;
        end
        t = 0; a = 0; model_end = MAXC - 1;
        while (t < MAXC) begin
            v = t + tab_stall[a];
            for (int c = t; c <= v && c < MAXC; c++) begin
                e_busy[c] = 1; e_req[c] = 1; e_addr[c] = a;
            end
            skip = (tab_dur[a] == 0);
            if (skip) begin
                ec = v + 1;
            end else begin
                pe = tab_dur[a] * TD;
                for (int k = 0; k < pe + TD; k++) begin
                    if (v + 1 + k < MAXC) begin
                        e_busy[v+1+k] = 1;
                        if (k < pe) begin
                            e_play[v+1+k] = a;
                            e_spk[v+1+k] = (tab_hp[a] != 0) && (((k / tab_hp[a]) % 2) == 1);
                        end
                    end
                end
                ec = v + 1 + pe + TD;
            end
            se = (tab_last[a] != 0) || (a == 31);
            if (se && !lp) begin
                if (ec < MAXC) e_done[ec] = 1;
                model_end = ec;
                break;
            end
            a = se ? 0 : a + 1;
            if (skip) begin
                if (ec < MAXC) e_busy[ec] = 1;
                t = ec + 1;
            end else begin
                t = ec;
            end
        end
        cur = -1;
        for (int c = 0; c < MAXC; c++) begin
            if (e_play[c] >= 0) cur = e_play[c];
            e_note[c] = cur;
        end
    endtask

    // LUT model: answers a held request after tab_stall[addr] extra cycles,
    // drives misleading data whenever valid is low.
    initial begin
        int wcnt;
        wcnt = 0;
        lif.lut_valid = 1'b0; lif.lut_half_period = 18'd1; lif.lut_dur = 8'd0; lif.lut_last = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                lif.lut_valid = 1'b0; wcnt = 0;
            end else if (lif.lut_valid) begin
                lif.lut_valid = 1'b0; wcnt = 0;
                lif.lut_half_period = 18'd1; lif.lut_dur = 8'd0; lif.lut_last = 1'b1;
            end else if (lif.lut_req) begin
                if (wcnt == tab_stall[int'(lif.lut_addr)]) begin
                    lif.lut_valid       = 1'b1;
                    lif.lut_half_period = PW'(tab_hp[int'(lif.lut_addr)]);
                    lif.lut_dur         = DW'(tab_dur[int'(lif.lut_addr)]);
                    lif.lut_last        = (tab_last[int'(lif.lut_addr)] != 0);
                end else begin
                    wcnt++;
                end
            end
        end
    end

    task automatic run_seq(input string name, input int n, input bit lp);
        logic [13:0] got, exp;
        build_model(lp);
        loop = lp;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            raw_v[c] = {spk, busy, done, lif.lut_req, lif.lut_addr, note_idx};
            exp = {e_spk[c], e_busy[c], e_done[c], e_req[c],
                   e_req[c] ? 5'(e_addr[c]) : 5'd0,
                   (e_note[c] >= 0) ? 5'(e_note[c]) : 5'd0};
            got = {spk, busy, done, lif.lut_req,
                   e_req[c] ? lif.lut_addr : 5'd0,
                   (e_note[c] >= 0) ? note_idx : 5'd0};
            chk(name, c, 32'(got), 32'(exp));
        end
    endtask

    task automatic idle_check(input string name);
        @(negedge clk);
        chk(name, 0, {28'd0, spk, busy, done, lif.lut_req}, 32'd0);
    endtask

    initial begin
        clear_tab();
        #2;
        chk("reset_state", 0, {18'd0, spk, busy, done, lif.lut_req, lif.lut_addr, note_idx}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        // Two tones, normal end.
        set_entry(0, 3, 2, 0, 1);
        set_entry(1, 5, 1, 1, 1);
        run_seq("two_tones", 58, 1'b0);
        chk("pin_spk_c4", 4, 32'(raw_v[4][13]), 32'd0);
        chk("pin_spk_c5", 5, 32'(raw_v[5][13]), 32'd1);
        chk("pin_addr_c32", 32, 32'(raw_v[32][9:5]), 32'd1);
        chk("pin_note_c34", 34, 32'(raw_v[34][4:0]), 32'd1);
        chk("pin_done_c54", 54, 32'(raw_v[54][11]), 32'd1);
        chk("pin_busy_c54", 54, 32'(raw_v[54][12]), 32'd0);

        // Rest between tones.
        clear_tab();
        set_entry(0, 3, 1, 0, 1);
        set_entry(1, 0, 3, 0, 1);
        set_entry(2, 4, 1, 1, 1);
        build_model(1'b0);
        run_seq("rest", model_end + 4, 1'b0);

        // Skipped entry in the middle.
        clear_tab();
        set_entry(0, 2, 1, 0, 1);
        set_entry(1, 5, 0, 0, 1);
        set_entry(2, 3, 1, 1, 1);
        build_model(1'b0);
        run_seq("skip", model_end + 4, 1'b0);
        chk("pin_skip_req_c24", 24, 32'(raw_v[24][10]), 32'd0);
        chk("pin_skip_addr_c25", 25, 32'(raw_v[25][9:5]), 32'd2);

        // Looping sequence, then stop while a tone is high.
        clear_tab();
        set_entry(0, 3, 1, 0, 1);
        set_entry(1, 2, 1, 0, 1);
        set_entry(2, 4, 1, 1, 1);
        run_seq("loop", 72, 1'b1);
        chk("pin_loop_addr_c66", 66, 32'(raw_v[66][10:5]), 32'h20);
        stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        idle_check("stop_idle");
        idle_check("stop_no_done");
        loop = 1'b0;

        // start and stop together: stop wins.
        @(posedge clk); #1 begin start = 1'b1; stop = 1'b1; end
        @(posedge clk); #1 begin start = 1'b0; stop = 1'b0; end
        idle_check("start_stop");

        // LUT stalls its response for 7 cycles.
        clear_tab();
        set_entry(0, 3, 1, 1, 7);
        build_model(1'b0);
        run_seq("stall", model_end + 4, 1'b0);

        // Async reset in the middle of a note with spk high.
        clear_tab();
        set_entry(0, 3, 2, 0, 1);
        set_entry(1, 5, 1, 1, 1);
        run_seq("pre_reset", 6, 1'b0);
        #2 rst = 1'b1;
        #1 chk("async_reset", 0, {18'd0, spk, busy, done, lif.lut_req, lif.lut_addr, note_idx}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        run_seq("after_reset", 58, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
